// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: fetch / byte-unpack / compute sequencer for the Minilab1 matrix-vector MAC array.
// Define MM_SEQ_PERF_CNT_EN to enable the busy-cycle counter on cycle_cnt (tied to 0 otherwise).
module mm_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DIM     = 8,
  parameter int ADDR_W  = 32,
  parameter int MAC_LAT = 2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  output logic [ADDR_W-1:0]       mem_address,
  output logic                    mem_read,
  input  logic                    mem_waitrequest,
  input  logic [DIM*DATA_W-1:0]   mem_readdata,
  input  logic                    mem_readdatavalid,
  output logic [DIM:0]            fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             cycle_cnt
);

  localparam int CW = $clog2(DIM + 1);
  localparam int IW = (DIM < 2) ? 1 : $clog2(DIM);
  localparam int DW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_COMPUTE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [DIM:0] EN_LSB = {{DIM{1'b0}}, 1'b1};

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] word_idx, word_idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;            // byte index in FILL, cycle index in COMPUTE
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          mac_clr_q;
  logic [DIM-1:0][DATA_W-1:0] word_q;

  always_comb begin
    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    state_nxt     = state;
    word_idx_nxt  = word_idx;
    cnt_nxt       = cnt;
    drain_cnt_nxt = drain_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_RD_REQ;
          word_idx_nxt = '0;
        end
      end
      S_RD_REQ: begin
        if (!mem_waitrequest) state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_readdatavalid) begin
          state_nxt = S_FILL;
          cnt_nxt   = '0;
        end
      end
      S_FILL: begin
        if (cnt == CW'(DIM - 1)) begin
          cnt_nxt = '0;
          if (word_idx == CW'(DIM)) begin
            state_nxt = S_COMPUTE;
          end else begin
            word_idx_nxt = word_idx + 1'b1;
            state_nxt    = S_RD_REQ;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_COMPUTE: begin
        if (cnt == CW'(DIM - 1)) begin
          cnt_nxt       = '0;
          drain_cnt_nxt = '0;
          state_nxt     = (MAC_LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DW'(MAC_LAT - 1)) state_nxt = S_DONE;
        else drain_cnt_nxt = drain_cnt + 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      word_idx  <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      mac_clr_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_idx  <= word_idx_nxt;
      cnt       <= cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      mac_clr_q <= (state == S_IDLE) && start;
    end
  end

  // NOTE: the word buffer is pure datapath and is left unreset; fifo_wr_data is gated by state instead.
  always_ff @(posedge clk) begin
    if (state == S_RD_WAIT && mem_readdatavalid) word_q <= mem_readdata;
  end

  assign busy         = (state != S_IDLE);
  assign mem_read     = (state == S_RD_REQ);
  assign mem_address  = mem_read ? ADDR_W'(word_idx) : '0;
  assign fifo_wr_en   = (state == S_FILL) ? (EN_LSB << word_idx) : '0;
  assign fifo_wr_data = (state == S_FILL) ? word_q[cnt[IW-1:0]] : '0;
  assign mac_clr      = mac_clr_q;
  assign mac_en       = (state == S_COMPUTE);
  assign done         = (state == S_DONE);

`ifdef MM_SEQ_PERF_CNT_EN
  logic [15:0] perf_cnt, perf_inc, cycle_q;

  assign perf_inc = (perf_cnt == 16'hFFFF) ? perf_cnt : perf_cnt + 16'd1;

  // The DONE cycle is itself busy, so the published count includes it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      perf_cnt <= '0;
      cycle_q  <= '0;
    end else begin
      if (state == S_IDLE && start) perf_cnt <= '0;
      else if (busy)                perf_cnt <= perf_inc;
      if (state == S_DONE)          cycle_q  <= perf_inc;
    end
  end

  assign cycle_cnt = cycle_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule
